// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester count, port identifiers and the word-alignment mask.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; when both
// request, the port that did not win last time gets the slot.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_lastGrant,
    output logic               o_winner,
    output logic               o_valid
);

    // Pick a winner from the current requests and the previous grant
    always_comb begin
        o_valid  = |i_req;
        o_winner = PORT_CPU;
        if (i_req[PORT_CPU] && i_req[PORT_DBG]) begin
            o_winner = ~i_lastGrant;
        end else if (i_req[PORT_DBG]) begin
            o_winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path
// (port 0) and the debug/loader port (port 1). Each granted request gets
// one ACCESS cycle followed by a registered response with error flag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WORDS = 256,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_readData
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * ADDR_WORDS);

    state_t              r_state;
    state_t              w_nextState;

    logic                r_lastGrant;
    logic                r_winId;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_err0;
    logic                r_err1;

    logic [NUM_REQ-1:0]  w_req;
    logic                w_arbWinner;
    logic                w_arbValid;
    logic                w_take;
    logic                w_ok;
    logic [DATA_W-1:0]   w_loadData;

    assign w_req = {p1_req, p0_req};

    rr_arb2 u_rrArb (
        .i_req       (w_req),
        .i_lastGrant (r_lastGrant),
        .o_winner    (w_arbWinner),
        .o_valid     (w_arbValid)
    );

    // A new request is accepted whenever the memory slot is free (IDLE or RESP)
    always_comb begin
        w_take     = ((r_state == IDLE) || (r_state == RESP)) && w_arbValid;
        w_ok       = ((r_addr[1:0] & ALIGN_MASK) == 2'b00) && (r_addr < ADDR_LIMIT);
        w_loadData = (w_ok && !r_we) ? mem_readData : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus grant, response-valid and memory strobes
    always_comb begin
        w_nextState   = r_state;
        p0_gnt        = 1'b0;
        p1_gnt        = 1'b0;
        p0_rvalid     = 1'b0;
        p1_rvalid     = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arbValid) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                p0_gnt        = (r_winId == PORT_CPU);
                p1_gnt        = (r_winId == PORT_DBG);
                mem_address   = r_addr;
                mem_writeData = r_wdata;
                mem_memRead   = w_ok & ~r_we;
                mem_memWrite  = w_ok & r_we & rst_n;
                w_nextState   = RESP;
            end
            RESP: begin
                p0_rvalid   = (r_winId == PORT_CPU) & rst_n;
                p1_rvalid   = (r_winId == PORT_DBG) & rst_n;
                w_nextState = w_arbValid ? ACCESS : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who won for the next tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastGrant <= PORT_DBG;
            r_winId     <= PORT_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (w_take) begin
            r_lastGrant <= w_arbWinner;
            r_winId     <= w_arbWinner;
            r_we        <= (w_arbWinner == PORT_DBG) ? p1_we    : p0_we;
            r_addr      <= (w_arbWinner == PORT_DBG) ? p1_addr  : p0_addr;
            r_wdata     <= (w_arbWinner == PORT_DBG) ? p1_wdata : p0_wdata;
        end
    end

    // Capture the access result into the winner's response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (r_winId == PORT_CPU) begin
                r_rdata0 <= w_loadData;
                r_err0   <= ~w_ok;
            end else begin
                r_rdata1 <= w_loadData;
                r_err1   <= ~w_ok;
            end
        end
    end

    assign p0_rdata = r_rdata0;
    assign p0_err   = r_err0;
    assign p1_rdata = r_rdata1;
    assign p1_err   = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a small behavioural memory sits behind the
// DUT, and a transaction-level model predicts grants, responses and memory
// contents from the arbitration and addressing rules.
module tb_dmem_arbiter;

    localparam int ADDR_WORDS = 256;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0]       p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic              p0_gnt, p0_rvalid, p0_err;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0]       p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic              p1_gnt, p1_rvalid, p1_err;
    logic [DATA_W-1:0] p1_rdata;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memRead, mem_memWrite;
    logic [DATA_W-1:0] mem_readData;

    logic [31:0]       memArr [0:ADDR_WORDS-1];
    bit                memClear = 1'b1;

    int                nAsserts = 0;
    int                nFail = 0;

    txn_t              q0[$];
    txn_t              q1[$];
    txn_t              cur[2];
    bit                hold[2];
    bit                randomGaps = 1'b0;

    bit                lastWin;
    bit                prevGnt;
    bit                respValid;
    bit                respPort;
    logic [31:0]       respRdata;
    logic              respErr;
    logic [31:0]       heldRdata[2];
    logic              heldErr[2];
    logic [31:0]       refMem[ADDR_WORDS];

    dmem_arbiter #(.ADDR_WORDS(ADDR_WORDS), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p0_req        (p0_req),
        .p0_we         (p0_we),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_gnt        (p0_gnt),
        .p0_rvalid     (p0_rvalid),
        .p0_err        (p0_err),
        .p0_rdata      (p0_rdata),
        .p1_req        (p1_req),
        .p1_we         (p1_we),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_gnt        (p1_gnt),
        .p1_rvalid     (p1_rvalid),
        .p1_err        (p1_err),
        .p1_rdata      (p1_rdata),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_readData  (mem_readData)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Single-port data memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < ADDR_WORDS; i++) memArr[i] <= '0;
        end else if (mem_memWrite) begin
            memArr[mem_address[9:2]] <= mem_writeData;
        end
    end

    assign mem_readData = memArr[mem_address[9:2]];

    // Hard stop in case something wedges the stimulus sequence
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic bit addrOk(input logic [31:0] addr);
        return ((addr % 4) == 0) && (addr < 32'(4 * ADDR_WORDS));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic driveReq();
        p0_req   = hold[0];
        p0_we    = cur[0].we;
        p0_addr  = cur[0].addr;
        p0_wdata = cur[0].wdata;
        p1_req   = hold[1];
        p1_we    = cur[1].we;
        p1_addr  = cur[1].addr;
        p1_wdata = cur[1].wdata;
    endtask

    task automatic modelReset();
        lastWin   = 1'b1;
        prevGnt   = 1'b0;
        respValid = 1'b0;
        respPort  = 1'b0;
        respRdata = '0;
        respErr   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            heldRdata[p] = '0;
            heldErr[p]   = 1'b0;
            hold[p]      = 1'b0;
            cur[p]       = mk(1'b0, 32'h0, 32'h0);
        end
        driveReq();
    endtask

    // Raise a request on every idle port that has queued work
    task automatic applyStimulus();
        for (int p = 0; p < 2; p++) begin
            if (hold[p]) continue;
            if (randomGaps && ($urandom_range(0, 2) == 0)) continue;
            if (p == 0 && q0.size() > 0) begin
                cur[0]  = q0.pop_front();
                hold[0] = 1'b1;
            end else if (p == 1 && q1.size() > 0) begin
                cur[1]  = q1.pop_front();
                hold[1] = 1'b1;
            end
        end
        driveReq();
    endtask

    // One clock of the reference model; entered and left just after a negedge
    task automatic stepCycle();
        bit [1:0] reqs;
        bit       expG;
        bit       win;
        bit       ok;
        int       idx;
        txn_t     t;
        reqs = {hold[1], hold[0]};
        @(posedge clk);
        @(negedge clk);
        expG = !prevGnt && (reqs != 2'b00);
        win  = (reqs == 2'b11) ? ~lastWin : reqs[1];
        checkBit("p0_gnt", p0_gnt, expG && (win == 1'b0));
        checkBit("p1_gnt", p1_gnt, expG && (win == 1'b1));
        checkBit("p0_rvalid", p0_rvalid, respValid && (respPort == 1'b0));
        checkBit("p1_rvalid", p1_rvalid, respValid && (respPort == 1'b1));
        if (respValid) begin
            heldRdata[respPort] = respRdata;
            heldErr[respPort]   = respErr;
        end
        checkOutput("p0_rdata", p0_rdata, heldRdata[0]);
        checkBit("p0_err", p0_err, heldErr[0]);
        checkOutput("p1_rdata", p1_rdata, heldRdata[1]);
        checkBit("p1_err", p1_err, heldErr[1]);
        respValid = 1'b0;
        if (expG) begin
            t  = cur[win];
            ok = addrOk(t.addr);
            checkOutput("mem_address", mem_address, t.addr);
            checkBit("mem_memWrite", mem_memWrite, ok && t.we);
            checkBit("mem_memRead", mem_memRead, ok && !t.we);
            if (t.we) checkOutput("mem_writeData", mem_writeData, t.wdata);
            respRdata = '0;
            respErr   = !ok;
            if (ok) begin
                idx = int'(t.addr / 4);
                if (t.we) refMem[idx] = t.wdata;
                else      respRdata   = refMem[idx];
            end
            respValid = 1'b1;
            respPort  = win;
            lastWin   = win;
            hold[win] = 1'b0;
        end
        prevGnt = expG;
        applyStimulus();
    endtask

    task automatic runUntilDrained(input int maxCycles);
        int n = 0;
        applyStimulus();
        while ((q0.size() > 0 || q1.size() > 0 || hold[0] || hold[1] || respValid) && n < maxCycles) begin
            stepCycle();
            n++;
        end
        nAsserts++;
        assert (n < maxCycles) else begin
            nFail++;
            $error("[TB] FAIL drainTimeout observed=%0d expected_below=%0d", n, maxCycles);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        memClear = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBit("rst_p0_gnt", p0_gnt, 1'b0);
        checkBit("rst_p1_gnt", p1_gnt, 1'b0);
        checkBit("rst_p0_rvalid", p0_rvalid, 1'b0);
        checkBit("rst_p1_rvalid", p1_rvalid, 1'b0);
        checkBit("rst_p0_err", p0_err, 1'b0);
        checkBit("rst_p1_err", p1_err, 1'b0);
        checkOutput("rst_p0_rdata", p0_rdata, 32'h0);
        checkOutput("rst_p1_rdata", p1_rdata, 32'h0);
        checkBit("rst_memRead", mem_memRead, 1'b0);
        checkBit("rst_memWrite", mem_memWrite, 1'b0);
        checkOutput("rst_mem_address", mem_address, 32'h0);
        checkOutput("rst_mem_writeData", mem_writeData, 32'h0);
        for (int i = 0; i < ADDR_WORDS; i++) refMem[i] = '0;
        rst_n    = 1'b1;
        memClear = 1'b0;
    endtask

    // Directed scenarios followed by a randomized mixed-traffic run
    initial begin
        logic [31:0] addr;
        modelReset();

        $display("[TB] reset");
        doReset();

        $display("[TB] p0 store then load");
        q0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        runUntilDrained(50);
        checkOutput("p0_load_after_store", p0_rdata, 32'hDEADBEEF);

        $display("[TB] both ports loading continuously");
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        q0.push_back(mk(1'b0, 32'h14, 32'h0));
        q0.push_back(mk(1'b0, 32'h18, 32'h0));
        q1.push_back(mk(1'b0, 32'h10, 32'h0));
        q1.push_back(mk(1'b0, 32'h20, 32'h0));
        q1.push_back(mk(1'b0, 32'h3FC, 32'h0));
        runUntilDrained(50);

        $display("[TB] p1 misaligned store and out-of-range load");
        q1.push_back(mk(1'b1, 32'h13, 32'hCAFEF00D));
        runUntilDrained(20);
        checkBit("misaligned_err", p1_err, 1'b1);
        checkOutput("misaligned_rdata", p1_rdata, 32'h0);
        q1.push_back(mk(1'b0, 32'h400, 32'h0));
        runUntilDrained(20);
        checkBit("out_of_range_err", p1_err, 1'b1);
        checkOutput("out_of_range_rdata", p1_rdata, 32'h0);
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        runUntilDrained(20);
        checkOutput("word10_unchanged", p0_rdata, 32'hDEADBEEF);

        $display("[TB] reset during ACCESS of a p0 store");
        cur[0]  = mk(1'b1, 32'h10, 32'h12345678);
        hold[0] = 1'b1;
        driveReq();
        @(posedge clk);
        @(negedge clk);
        checkBit("rstAcc_gnt", p0_gnt, 1'b1);
        rst_n   = 1'b0;
        hold[0] = 1'b0;
        driveReq();
        #1;
        checkBit("rstAcc_memWrite", mem_memWrite, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkBit("rstAcc_no_rvalid", p0_rvalid, 1'b0);
        checkBit("rstAcc_no_gnt0", p0_gnt, 1'b0);
        checkBit("rstAcc_no_gnt1", p1_gnt, 1'b0);
        rst_n = 1'b1;
        modelReset();
        q0.push_back(mk(1'b0, 32'h10, 32'h0));
        q1.push_back(mk(1'b0, 32'h10, 32'h0));
        runUntilDrained(20);
        checkOutput("rstAcc_old_value_p0", p0_rdata, 32'hDEADBEEF);
        checkOutput("rstAcc_old_value_p1", p1_rdata, 32'hDEADBEEF);

        $display("[TB] back-to-back p1 loads");
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 32'(4 * i + 16), 32'h0));
        runUntilDrained(30);

        $display("[TB] randomized traffic");
        randomGaps = 1'b1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'(4 * $urandom_range(0, ADDR_WORDS - 1) + $urandom_range(1, 3));
                1:       addr = 32'(4 * ADDR_WORDS + 4 * $urandom_range(0, 1000));
                default: addr = 32'(4 * $urandom_range(0, ADDR_WORDS - 1));
            endcase
            if (i % 2 == 0) q0.push_back(mk(1'($urandom_range(0, 1)), addr, $urandom()));
            else            q1.push_back(mk(1'($urandom_range(0, 1)), addr, $urandom()));
        end
        runUntilDrained(3000);
        randomGaps = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU datapath load/store path, port 1 is the debug/loader port.
- Round-robin arbitration with a request/grant handshake; one memory access per granted request.
- Registered response with alignment and range checking.
- Sits between the requesters and the data memory's address/writeData/readData/memRead/memWrite interface. The memory writes on posedge clk and reads combinationally.

Parameters:
- ADDR_WORDS, 256, number of 32-bit words behind the memory; byte addresses at or above 4*ADDR_WORDS are out of range.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt
- p0_we  in  1  1=store, 0=load
- p0_addr  in  32  byte address
- p0_wdata  in  DATA_W  store data
- p0_gnt  out  1  one-cycle pulse: request accepted, memory accessed this cycle
- p0_rvalid  out  1  one-cycle response pulse, cycle after p0_gnt
- p0_err  out  1  valid with p0_rvalid: misaligned or out of range
- p0_rdata  out  DATA_W  load data, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_err, p1_rdata: same as port 0
- mem_address  out  32  to memory address
- mem_writeData  out  DATA_W  to memory writeData
- mem_memRead  out  1  to memory memRead
- mem_memWrite  out  1  to memory memWrite
- mem_readData  in  DATA_W  from memory readData

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All gnt, rvalid and err outputs are 0; all rdata outputs are 0.
  - mem_memRead=0, mem_memWrite=0; mem_address and mem_writeData are 0.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration (in IDLE or RESP, sampled at posedge):
  - One requester active: that port wins.
  - Both active: the port that is not last_grant wins.
  - On a win: latch the winner's id/we/addr/wdata, update last_grant, go to ACCESS.
  - No request: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS (exactly 1 cycle):
  - Drive the winner's gnt=1.
  - Drive mem_address and mem_writeData from the latched values.
  - Set ok = (addr[1:0]==0) && (addr < 4*ADDR_WORDS).
  - mem_memRead = ok & ~we; mem_memWrite = ok & we & rst_n. Gating with rst_n means no write lands during a reset cycle.
  - At the end of the cycle capture mem_readData (loads) or 0 (stores and errors) into the winner's rdata, and set err = ~ok. Go to RESP.
- RESP:
  - Winner's rvalid=1 for one cycle; rdata/err hold until that port's next response.
  - Arbitration runs in the same cycle, so back-to-back throughput is 1 access per 2 cycles.
- Latency: req seen at edge N → gnt during cycle N+1 → rvalid during cycle N+2.
- Error requests consume an ACCESS slot but never touch memory. A store to an erroneous address leaves memory unchanged.
- A requester dropping req before gnt is a protocol violation; behaviour is undefined, but the FSM must still return to IDLE.
- Reset asserted in ACCESS or RESP:
  - Return to IDLE next edge; no rvalid is issued; last_grant resets.
  - The suppressed memory write in that cycle is guaranteed by the rst_n gating.
- Only one gnt and at most one rvalid are ever high; gnt and rvalid are never high for the same port in the same cycle.

Decomposition:
- Shared package/header dmem_arb_pkg:
  - state encodings IDLE/ACCESS/RESP;
  - NUM_REQ=2;
  - port id constants PORT_CPU=0, PORT_DBG=1;
  - ALIGN_MASK=2'b11.
- One sub-module: rr_arb2.
  - Combinational 2-way round-robin pick from req[1:0] and last_grant.
  - Outputs winner id and a valid flag.
- Top-level FSM, request latch and response registers stay in dmem_arbiter.

Test Plan:
- Reset then p0 store addr 0x10 data 0xDEADBEEF → p0_gnt next cycle with mem_memWrite=1, mem_address=0x10. Then p0 load 0x10 → p0_rvalid with p0_rdata=0xDEADBEEF, p0_err=0.
- p0 and p1 both hold load requests continuously from reset → grants alternate p0,p1,p0,p1 with 2-cycle spacing; never two gnts in one cycle.
- p1 store addr 0x13 (misaligned), then p1 load addr 0x400 with ADDR_WORDS=256 → p1_err=1 both times, p1_rdata=0, mem_memWrite and mem_memRead stay 0, and memory word 0x10 is unchanged.
- p0 store issued, rst_n=0 during its ACCESS cycle → mem_memWrite=0 that cycle, no p0_rvalid, and a later load returns the old value. After release, a simultaneous p0/p1 request grants p0 first.
- Back-to-back p1 loads with p0 idle → p1_gnt every 2 cycles, with RESP going directly to ACCESS without passing through IDLE.
